// File: rtl/apb_quad_gen.sv
// apb_quad_gen: APB-programmed quadrature A/B pulse generator.
// Emits Gray-coded A/B edges at a programmable period, for a fixed edge count
// or continuously. It keeps a signed position that tracks what a quadrature
// decoder watching the same lines would accumulate.
//
// Bus handshake: a write is taken on the clock where psel & penable & pwrite
// are all high. A read is captured into apb_prdata on the setup clock, where
// psel is high and penable and pwrite are low. The data stays on apb_prdata
// through the access phase. There is no wait state; every access completes
// in two clocks.
//
// Debug visibility: the FSM state (IDLE/RUN) is reported on the busy output
// and in STAT[0].

module apb_quad_gen #(
    parameter int DIV_BITS  = 16,
    parameter int STEP_BITS = 32
) (
    input  logic        apb_clock,
    input  logic        apb_resetn,
    input  logic        apb_psel,
    input  logic        apb_penable,
    input  logic        apb_pwrite,
    input  logic [11:0] apb_paddr,
    input  logic [31:0] apb_pwdata,
    output logic [31:0] apb_prdata,
    output logic        quad_a,
    output logic        quad_b,
    output logic        busy,
    output logic        irq
);

    localparam logic [11:0] ADDR_CTRL   = 12'h000;
    localparam logic [11:0] ADDR_STAT   = 12'h004;
    localparam logic [11:0] ADDR_DIV    = 12'h008;
    localparam logic [11:0] ADDR_STEPS  = 12'h00C;
    localparam logic [11:0] ADDR_POS    = 12'h010;
    localparam logic [11:0] ADDR_REMAIN = 12'h014;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                 state;
    logic                   ctrl_start;
    logic                   ctrl_stop;
    logic                   ctrl_dir;
    logic                   ctrl_cont;
    logic                   ctrl_irq_en;
    logic                   done;
    logic [DIV_BITS-1:0]    div_q;
    logic [STEP_BITS-1:0]   steps_q;
    logic [31:0]            pos_q;
    logic [STEP_BITS-1:0]   remain_q;
    logic [DIV_BITS-1:0]    divcnt_q;
    logic [1:0]             phase_q;

    // Bus decode
    logic wr_en;
    logic rd_en;
    logic wr_ctrl;
    logic wr_stat;
    logic wr_div;
    logic wr_steps;
    logic wr_pos;

    assign wr_en    = apb_psel & apb_penable & apb_pwrite;
    assign rd_en    = apb_psel & ~apb_penable & ~apb_pwrite;
    assign wr_ctrl  = wr_en && (apb_paddr == ADDR_CTRL);
    assign wr_stat  = wr_en && (apb_paddr == ADDR_STAT);
    assign wr_div   = wr_en && (apb_paddr == ADDR_DIV);
    assign wr_steps = wr_en && (apb_paddr == ADDR_STEPS);
    assign wr_pos   = wr_en && (apb_paddr == ADDR_POS);

    // Stop outranks start when both are written together
    logic stop_req;
    logic start_req;
    logic start_cont;

    assign stop_req   = wr_ctrl && apb_pwdata[1];
    assign start_req  = wr_ctrl && apb_pwdata[0] && !apb_pwdata[1];
    // The cont bit written with start decides whether a zero count still runs
    assign start_cont = apb_pwdata[3];

    // Edge generation: one phase step when the divider reaches DIV
    logic       edge_tick;
    logic       advance;
    logic       final_edge;
    logic       zero_done;
    logic       set_done;
    logic [1:0] phase_next;

    assign edge_tick  = (state == S_RUN) && (divcnt_q == div_q);
    assign advance    = edge_tick && !stop_req;
    // A zero remain count in counted mode also ends the run, so it never underflows
    assign final_edge = advance && !ctrl_cont && (remain_q <= STEP_BITS'(1));
    // A start with nothing to do reports done one clock after the write
    assign zero_done  = (state == S_IDLE) && !start_req && ctrl_start;
    assign set_done   = final_edge | zero_done;
    // Phase index 0..3 maps to (A,B) = 00,10,11,01; forward walks upwards
    assign phase_next = ctrl_dir ? (phase_q - 2'd1) : (phase_q + 2'd1);

    // Configuration registers; dir changes take effect at the next edge
    always_ff @(posedge apb_clock or negedge apb_resetn) begin
        if (!apb_resetn) begin
            ctrl_dir    <= 1'b0;
            ctrl_cont   <= 1'b0;
            ctrl_irq_en <= 1'b0;
            div_q       <= '0;
            steps_q     <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_dir    <= apb_pwdata[2];
                ctrl_cont   <= apb_pwdata[3];
                ctrl_irq_en <= apb_pwdata[4];
            end
            if (wr_div) begin
                div_q <= apb_pwdata[DIV_BITS-1:0];
            end
            if (wr_steps) begin
                steps_q <= apb_pwdata[STEP_BITS-1:0];
            end
        end
    end

    // Generator FSM: divider, phase, remaining count, start/stop/done flags
    always_ff @(posedge apb_clock or negedge apb_resetn) begin
        if (!apb_resetn) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            ctrl_start <= 1'b0;
            ctrl_stop  <= 1'b0;
            done       <= 1'b0;
            remain_q   <= '0;
            divcnt_q   <= '0;
            phase_q    <= 2'd0;
            quad_a     <= 1'b0;
            quad_b     <= 1'b0;
        end else begin
            // Stop reads back as 1 for one clock after it is written
            ctrl_stop <= stop_req;

            // The set of done outranks a W1 clear in the same clock
            if (set_done) begin
                done <= 1'b1;
            end else if (wr_stat && apb_pwdata[1]) begin
                done <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (start_req) begin
                        ctrl_start <= 1'b1;
                        if ((steps_q != '0) || start_cont) begin
                            state    <= S_RUN;
                            busy     <= 1'b1;
                            remain_q <= steps_q;
                            divcnt_q <= '0;
                        end
                    end else if (ctrl_start) begin
                        ctrl_start <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (stop_req) begin
                        // Outputs, phase and remain all hold where they are
                        state      <= S_IDLE;
                        busy       <= 1'b0;
                        ctrl_start <= 1'b0;
                    end else if (edge_tick) begin
                        divcnt_q <= '0;
                        phase_q  <= phase_next;
                        quad_a   <= phase_next[1] ^ phase_next[0];
                        quad_b   <= phase_next[1];
                        if (!ctrl_cont && (remain_q != '0)) begin
                            remain_q <= remain_q - STEP_BITS'(1);
                        end
                        if (final_edge) begin
                            state      <= S_IDLE;
                            busy       <= 1'b0;
                            ctrl_start <= 1'b0;
                        end
                    end else begin
                        // A DIV lowered below divcnt makes this wrap before matching
                        divcnt_q <= divcnt_q + DIV_BITS'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Signed position: +1 per forward edge, -1 per reverse edge; a bus write wins
    always_ff @(posedge apb_clock or negedge apb_resetn) begin
        if (!apb_resetn) begin
            pos_q <= '0;
        end else if (wr_pos) begin
            pos_q <= apb_pwdata;
        end else if (advance) begin
            pos_q <= ctrl_dir ? (pos_q - 32'd1) : (pos_q + 32'd1);
        end
    end

    // Read data captured on the setup clock; unmapped offsets return 0
    always_ff @(posedge apb_clock or negedge apb_resetn) begin
        if (!apb_resetn) begin
            apb_prdata <= '0;
        end else if (rd_en) begin
            case (apb_paddr)
                ADDR_CTRL:   apb_prdata <= {27'd0, ctrl_irq_en, ctrl_cont, ctrl_dir,
                                            ctrl_stop, ctrl_start};
                ADDR_STAT:   apb_prdata <= {30'd0, done, busy};
                ADDR_DIV:    apb_prdata <= 32'(div_q);
                ADDR_STEPS:  apb_prdata <= 32'(steps_q);
                ADDR_POS:    apb_prdata <= pos_q;
                ADDR_REMAIN: apb_prdata <= 32'(remain_q);
                default:     apb_prdata <= '0;
            endcase
        end
    end

    assign irq = done & ctrl_irq_en;

endmodule

// File: tb/tb_apb_quad_gen.sv
// tb_apb_quad_gen: directed bench for apb_quad_gen.
// A small quadrature decoder model watches quad_a/quad_b so the emitted edge
// stream can be compared with the POS register.

module tb_apb_quad_gen;

  localparam logic [11:0] A_CTRL   = 12'h000;
  localparam logic [11:0] A_STAT   = 12'h004;
  localparam logic [11:0] A_DIV    = 12'h008;
  localparam logic [11:0] A_STEPS  = 12'h00C;
  localparam logic [11:0] A_POS    = 12'h010;
  localparam logic [11:0] A_REMAIN = 12'h014;

  // ---------------- clock / reset ----------------
  logic        apb_clock = 1'b0;
  logic        apb_resetn = 1'b0;
  logic        apb_psel = 1'b0;
  logic        apb_penable = 1'b0;
  logic        apb_pwrite = 1'b0;
  logic [11:0] apb_paddr = '0;
  logic [31:0] apb_pwdata = '0;
  logic [31:0] apb_prdata;
  logic        quad_a;
  logic        quad_b;
  logic        busy;
  logic        irq;

  always #5 apb_clock = ~apb_clock;

  apb_quad_gen #(.DIV_BITS(16), .STEP_BITS(32)) dut (
    .apb_clock  (apb_clock),
    .apb_resetn (apb_resetn),
    .apb_psel   (apb_psel),
    .apb_penable(apb_penable),
    .apb_pwrite (apb_pwrite),
    .apb_paddr  (apb_paddr),
    .apb_pwdata (apb_pwdata),
    .apb_prdata (apb_prdata),
    .quad_a     (quad_a),
    .quad_b     (quad_b),
    .busy       (busy),
    .irq        (irq)
  );

  // ---------------- counters ----------------
  int n_checks = 0;
  int n_pass = 0;

  // ---------------- decoder model ----------------
  int       dec_pos = 0;
  int       dec_base = 0;
  logic [1:0] dec_prev = 2'd0;

  function automatic logic [1:0] ab_to_idx(input logic a, input logic b);
    case ({a, b})
      2'b00:   return 2'd0;
      2'b10:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  always @(posedge apb_clock) begin
    logic [1:0] cur;
    #2;
    if (!apb_resetn) begin
      dec_pos = 0;
      dec_prev = 2'd0;
    end else begin
      cur = ab_to_idx(quad_a, quad_b);
      if (cur == dec_prev + 2'd1) dec_pos = dec_pos + 1;
      else if (cur == dec_prev - 2'd1) dec_pos = dec_pos - 1;
      dec_prev = cur;
    end
  end

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic apb_write(input logic [11:0] addr, input logic [31:0] data);
    @(negedge apb_clock);
    apb_psel = 1'b1;
    apb_pwrite = 1'b1;
    apb_penable = 1'b0;
    apb_paddr = addr;
    apb_pwdata = data;
    @(negedge apb_clock);
    apb_penable = 1'b1;
    @(negedge apb_clock);
    apb_psel = 1'b0;
    apb_penable = 1'b0;
    apb_pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] addr, output logic [31:0] data);
    @(negedge apb_clock);
    apb_psel = 1'b1;
    apb_pwrite = 1'b0;
    apb_penable = 1'b0;
    apb_paddr = addr;
    @(negedge apb_clock);
    apb_penable = 1'b1;
    @(negedge apb_clock);
    apb_psel = 1'b0;
    apb_penable = 1'b0;
    data = apb_prdata;
  endtask

  function automatic logic [31:0] ab(input logic a, input logic b);
    return {30'd0, a, b};
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  logic [31:0] rd;
  logic [1:0]  t2_seq [6];

  initial begin
    t2_seq = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11};

    // reset state
    repeat (3) @(negedge apb_clock);
    check("rst_prdata", apb_prdata, 32'h0);
    check("rst_quad", ab(quad_a, quad_b), 32'h0);
    check("rst_busy", {31'd0, busy}, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    apb_resetn = 1'b1;
    apb_read(A_STAT, rd);
    check("rst_stat", rd, 32'h0);
    apb_read(A_POS, rd);
    check("rst_pos", rd, 32'h0);

    // 1: DIV=3, STEPS=4 forward, edges every 4 clocks
    apb_write(A_DIV, 32'd3);
    apb_write(A_STEPS, 32'd4);
    dec_base = dec_pos;
    apb_write(A_CTRL, 32'h1);
    check("t1_busy_start", {31'd0, busy}, 32'h1);
    repeat (3) @(negedge apb_clock);
    check("t1_no_edge_yet", ab(quad_a, quad_b), 32'h0);
    @(negedge apb_clock);
    check("t1_edge1", ab(quad_a, quad_b), 32'h2);
    repeat (4) @(negedge apb_clock);
    check("t1_edge2", ab(quad_a, quad_b), 32'h3);
    repeat (4) @(negedge apb_clock);
    check("t1_edge3", ab(quad_a, quad_b), 32'h1);
    repeat (3) @(negedge apb_clock);
    check("t1_busy_before_last", {31'd0, busy}, 32'h1);
    @(negedge apb_clock);
    check("t1_edge4", ab(quad_a, quad_b), 32'h0);
    check("t1_busy_end", {31'd0, busy}, 32'h0);
    apb_read(A_POS, rd);
    check("t1_pos", rd, 32'd4);
    apb_read(A_STAT, rd);
    check("t1_stat", rd, 32'h2);
    apb_read(A_REMAIN, rd);
    check("t1_remain", rd, 32'h0);
    check("t1_decoder", dec_pos - dec_base, 32'd4);

    // 2: reverse, DIV=0, one edge per clock
    apb_write(A_STAT, 32'h2);
    apb_write(A_POS, 32'h0);
    apb_write(A_DIV, 32'd0);
    apb_write(A_STEPS, 32'd6);
    dec_base = dec_pos;
    apb_write(A_CTRL, 32'h5);
    for (int i = 0; i < 6; i++) begin
      @(negedge apb_clock);
      check($sformatf("t2_edge%0d", i), ab(quad_a, quad_b), {30'd0, t2_seq[i]});
    end
    check("t2_busy_end", {31'd0, busy}, 32'h0);
    apb_read(A_POS, rd);
    check("t2_pos", rd, 32'hFFFF_FFFA);
    check("t2_decoder", dec_pos - dec_base, 32'hFFFF_FFFA);

    // 3: continuous, stop after 10 edges
    apb_write(A_STAT, 32'h2);
    apb_write(A_POS, 32'h0);
    apb_write(A_DIV, 32'd1);
    dec_base = dec_pos;
    apb_write(A_CTRL, 32'h9);
    repeat (19) @(negedge apb_clock);
    apb_write(A_CTRL, 32'h2);
    check("t3_busy_after_stop", {31'd0, busy}, 32'h0);
    check("t3_quad_after_stop", ab(quad_a, quad_b), 32'h0);
    repeat (5) @(negedge apb_clock);
    check("t3_quad_held", ab(quad_a, quad_b), 32'h0);
    apb_read(A_POS, rd);
    check("t3_pos", rd, 32'd10);
    apb_read(A_STAT, rd);
    check("t3_stat", rd, 32'h0);
    check("t3_decoder", dec_pos - dec_base, 32'd10);

    // 4: zero-step start, done and irq, W1 clear
    apb_write(A_STEPS, 32'd0);
    apb_write(A_CTRL, 32'h11);
    check("t4_irq_pre", {31'd0, irq}, 32'h0);
    @(negedge apb_clock);
    check("t4_irq_set", {31'd0, irq}, 32'h1);
    check("t4_busy", {31'd0, busy}, 32'h0);
    check("t4_quad", ab(quad_a, quad_b), 32'h0);
    apb_read(A_CTRL, rd);
    check("t4_ctrl", rd, 32'h10);
    apb_read(A_STAT, rd);
    check("t4_stat_done", rd, 32'h2);
    apb_write(A_STAT, 32'h2);
    check("t4_irq_clr", {31'd0, irq}, 32'h0);
    apb_read(A_STAT, rd);
    check("t4_stat_clr", rd, 32'h0);

    // 5: POS wrap, then POS write coincident with an edge
    apb_write(A_POS, 32'h7FFF_FFFF);
    apb_write(A_STEPS, 32'd1);
    apb_write(A_DIV, 32'd0);
    apb_write(A_CTRL, 32'h1);
    repeat (2) @(negedge apb_clock);
    check("t5_busy_wrap", {31'd0, busy}, 32'h0);
    check("t5_quad_wrap", ab(quad_a, quad_b), 32'h2);
    apb_read(A_POS, rd);
    check("t5_pos_wrap", rd, 32'h8000_0000);
    apb_write(A_STAT, 32'h2);
    apb_write(A_DIV, 32'd3);
    apb_write(A_STEPS, 32'd2);
    apb_write(A_CTRL, 32'h1);
    @(negedge apb_clock);
    apb_write(A_POS, 32'd5);
    check("t5_quad_coinc", ab(quad_a, quad_b), 32'h3);
    apb_read(A_POS, rd);
    check("t5_pos_write_wins", rd, 32'd5);
    repeat (2) @(negedge apb_clock);
    check("t5_quad_last", ab(quad_a, quad_b), 32'h1);
    check("t5_busy_end", {31'd0, busy}, 32'h0);
    apb_read(A_POS, rd);
    check("t5_pos_end", rd, 32'd6);

    // 6: asynchronous reset mid-run
    apb_write(A_DIV, 32'd0);
    apb_write(A_STEPS, 32'd100);
    apb_write(A_CTRL, 32'h1);
    repeat (10) @(negedge apb_clock);
    check("t6_busy_run", {31'd0, busy}, 32'h1);
    #2;
    apb_resetn = 1'b0;
    #1;
    check("t6_quad_rst", ab(quad_a, quad_b), 32'h0);
    check("t6_busy_rst", {31'd0, busy}, 32'h0);
    check("t6_irq_rst", {31'd0, irq}, 32'h0);
    @(negedge apb_clock);
    apb_resetn = 1'b1;
    apb_read(A_REMAIN, rd);
    check("t6_remain", rd, 32'h0);
    apb_read(A_CTRL, rd);
    check("t6_ctrl", rd, 32'h0);
    apb_read(A_STAT, rd);
    check("t6_stat", rd, 32'h0);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_quad_gen.md
Name: apb_quad_gen

Overview:
- APB slave that generates a quadrature A/B pulse train. It is the transmit-side counterpart of the pulse_cnt quadrature decoder.
- Software programs edge period, edge count and direction. The block emits Gray-coded A/B edges and keeps a signed position count that matches what a decoder on the same lines would accumulate.
- It sits beside apb_adc behind the ahb2apb bridge in its own PER_BITS address slot. It drives the encoder loopback/test pins and raises local_int on completion.

Parameters:
DIV_BITS, 16, width of the edge-period divider register
STEP_BITS, 32, width of the edge-count and remaining-count registers

Ports:
apb_clock  input  1  single clock; all logic in this domain
apb_resetn  input  1  asynchronous active-low reset
apb_psel  input  1  APB select
apb_penable  input  1  APB enable
apb_pwrite  input  1  1 = write
apb_paddr  input  12  byte offset within the slot
apb_pwdata  input  32  write data
apb_prdata  output  32  read data, registered
quad_a  output  1  phase A
quad_b  output  1  phase B
busy  output  1  generator running
irq  output  1  done interrupt, level, gated by irq_en

Behaviour:
- Reset: quad_a=0, quad_b=0, busy=0, irq=0, apb_prdata=0, phase=0, all registers 0.
- Write strobe: psel & penable & pwrite.
- Read capture: apb_prdata loads on psel & !penable & !pwrite. Unmapped offsets read 0.
- Register map:
  - 0x00 CTRL: [0] start, W1 sets, self-clears; [1] stop, W1, self-clears next cycle; [2] dir, 0 = fwd, 1 = rev; [3] cont; [4] irq_en.
  - 0x04 STAT: [0] busy (RO); [1] done, sticky, W1 clears.
  - 0x08 DIV: [DIV_BITS-1:0]. Edge period is DIV+1 clocks.
  - 0x0C STEPS: edges to emit.
  - 0x10 POS: signed 32-bit, R/W.
  - 0x14 REMAIN: remaining edges, read-only.
- Phase sequence as (A,B):
  - fwd: 00→10→11→01→00
  - rev: 01→11→10→00→01
  - A pulse_cnt on the same lines counts +1 per fwd edge and −1 per rev edge.
- FSM states: IDLE, RUN.
  - IDLE→RUN on a start write with STEPS≠0 or cont=1. On entry, remain=STEPS, divcnt=0, busy=1 after that clock edge.
  - A start write with STEPS=0 and cont=0 causes no edges, sets done=1 the next cycle, and clears start.
  - In RUN, divcnt increments each clock. When divcnt==DIV: advance the phase one step in the current dir, POS±1, remain−1 (not in cont), divcnt=0.
  - The first edge appears DIV+1 clocks after the start-write edge. The following edges come every DIV+1 clocks.
  - RUN→IDLE on the clock of the final edge (remain 1→0, cont=0): busy=0, done=1, start cleared.
  - RUN→IDLE on a stop write: takes effect at that edge, no further edges, outputs hold their level, done not set, remain holds its value.
- Mid-run writes:
  - dir change: applies to the next edge.
  - DIV write: used at the next compare. If the new DIV is below divcnt, divcnt wraps at 2^DIV_BITS; software must stop before changing DIV.
  - start while busy: ignored.
  - STEPS write: affects only the next start.
- Simultaneous events:
  - POS write in the same cycle as an edge: the write wins.
  - done W1-clear in the same cycle as the final edge: done is set (the set wins).
  - stop and start in the same write: stop wins, stays IDLE.
- Arithmetic: POS wraps modulo 2^32 (0x7FFFFFFF+1 → 0x80000000). remain never goes below 0.
- irq = done & irq_en, combinational from registers.
- Async reset mid-run: immediate return to reset values.

Test Plan:
1. DIV=3, STEPS=4, dir=0, start → A,B edges at clocks 4,8,12,16 after the start edge: 00→10→11→01→00. POS=4, done=1, busy=0, REMAIN=0.
2. POS=0, DIV=0, STEPS=6, dir=1 → one edge per clock: 01,11,10,00,01,11. POS=−6 (0xFFFFFFFA). Loopback into pulse_cnt reads −6.
3. cont=1, DIV=1, start; after 10 edges write stop → exactly 10 edges, POS=10, busy=0 next cycle, done=0, outputs held.
4. STEPS=0, cont=0, start → no edges, done=1 one cycle later, irq=1 with irq_en=1. W1 to STAT[1] → done=0, irq=0.
5. POS=0x7FFFFFFF, STEPS=1, fwd → POS=0x80000000. A POS write of 5 coincident with an edge → POS reads 5.
6. Assert apb_resetn low mid-run (STEPS=100) → quad_a=quad_b=0, busy=0, REMAIN=0 asynchronously. A read of CTRL returns 0.
